// File: rtl/uart_pin_master.sv
// Serial command initiator for the uart_mcu pin-register protocol: sends 8N1
// command frames on uart_txd and collects the single read-response byte.
module uart_pin_master #(
  parameter int CLK_HZ      = 50_000_000,
  parameter int BAUD        = 115200,
  parameter int TIMEOUT_CYC = 100_000
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_wr,
  input  logic [2:0] req_idx,
  input  logic [7:0] req_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       rsp_err,
  output logic       busy,
  output logic       uart_txd,
  input  logic       uart_rxd
);

  localparam int BAUD_DIV = CLK_HZ / BAUD;
  localparam int HALF_DIV = BAUD_DIV / 2;
  localparam int BW       = $clog2(BAUD_DIV + 1);
  localparam int TW       = $clog2(TIMEOUT_CYC + 1);

  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
  localparam logic [BW-1:0] HALF_LAST = BW'(HALF_DIV - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYC - 1);

  if (BAUD_DIV < 4) begin : g_bad_baud
    $error("uart_pin_master: CLK_HZ/BAUD must be at least 4");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_TX_CMD,
    S_TX_DATA,
    S_RX_HUNT,
    S_RX_START,
    S_RX_DATA,
    S_DONE
  } state_t;

  state_t        state_q;
  logic          req_ready_q;
  logic          rsp_valid_q;
  logic [7:0]    rsp_data_q;
  logic          rsp_err_q;
  logic          txd_q;
  logic          wr_q;
  logic [7:0]    data_q;
  logic [9:0]    tx_shift_q;
  logic [3:0]    bit_cnt_q;
  logic [BW-1:0] baud_cnt_q;
  logic [TW-1:0] to_cnt_q;
  logic [7:0]    rx_shift_q;
  logic          rxd_meta_q;
  logic          rxd_sync_q;

  assign req_ready = req_ready_q;
  assign busy      = ~req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign uart_txd  = txd_q;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      rxd_meta_q <= 1'b1;
      rxd_sync_q <= 1'b1;
    end else begin
      rxd_meta_q <= uart_rxd;
      rxd_sync_q <= rxd_meta_q;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q     <= S_IDLE;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      txd_q       <= 1'b1;
      wr_q        <= 1'b0;
      data_q      <= '0;
      tx_shift_q  <= '0;
      bit_cnt_q   <= '0;
      baud_cnt_q  <= '0;
      to_cnt_q    <= '0;
      rx_shift_q  <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        // A request held valid through the completion cycle is taken on the
        // DONE exit edge, so back-to-back requests lose only one cycle.
        S_IDLE, S_DONE: begin
          if (req_valid) begin
            wr_q        <= req_wr;
            data_q      <= req_data;
            tx_shift_q  <= {1'b1, req_wr, 4'b0000, req_idx, 1'b0};
            bit_cnt_q   <= '0;
            baud_cnt_q  <= BAUD_LAST;
            req_ready_q <= 1'b0;
            state_q     <= S_TX_CMD;
          end else if (state_q == S_DONE) begin
            req_ready_q <= 1'b1;
            state_q     <= S_IDLE;
          end
        end

        S_TX_CMD, S_TX_DATA: begin
          if (baud_cnt_q != BAUD_LAST) begin
            baud_cnt_q <= baud_cnt_q + BW'(1);
          end else begin
            baud_cnt_q <= '0;
            if (bit_cnt_q != 4'd10) begin
              txd_q      <= tx_shift_q[0];
              tx_shift_q <= {1'b0, tx_shift_q[9:1]};
              bit_cnt_q  <= bit_cnt_q + 4'd1;
            end else if (state_q == S_TX_CMD && wr_q) begin
              // Payload start bit goes out on the same tick the command stop bit ends.
              txd_q      <= 1'b0;
              tx_shift_q <= {1'b0, 1'b1, data_q};
              bit_cnt_q  <= 4'd1;
              state_q    <= S_TX_DATA;
            end else if (state_q == S_TX_CMD) begin
              to_cnt_q <= '0;
              state_q  <= S_RX_HUNT;
            end else begin
              rsp_valid_q <= 1'b1;
              rsp_data_q  <= '0;
              rsp_err_q   <= 1'b0;
              state_q     <= S_DONE;
            end
          end
        end

        S_RX_HUNT: begin
          to_cnt_q <= to_cnt_q + TW'(1);
          if (to_cnt_q == TO_LAST) begin
            // Timeout takes priority over a start bit seen on the same edge.
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b1;
            state_q     <= S_DONE;
          end else if (!rxd_sync_q) begin
            baud_cnt_q <= '0;
            state_q    <= S_RX_START;
          end
        end

        S_RX_START: begin
          if (baud_cnt_q != HALF_LAST) begin
            baud_cnt_q <= baud_cnt_q + BW'(1);
          end else begin
            baud_cnt_q <= '0;
            if (rxd_sync_q) begin
              state_q <= S_RX_HUNT;
            end else begin
              bit_cnt_q <= '0;
              state_q   <= S_RX_DATA;
            end
          end
        end

        S_RX_DATA: begin
          if (baud_cnt_q != BAUD_LAST) begin
            baud_cnt_q <= baud_cnt_q + BW'(1);
          end else begin
            baud_cnt_q <= '0;
            if (bit_cnt_q != 4'd8) begin
              rx_shift_q <= {rxd_sync_q, rx_shift_q[7:1]};
              bit_cnt_q  <= bit_cnt_q + 4'd1;
            end else begin
              rsp_valid_q <= 1'b1;
              rsp_data_q  <= rx_shift_q;
              rsp_err_q   <= ~rxd_sync_q;
              state_q     <= S_DONE;
            end
          end
        end

        default: begin
          req_ready_q <= 1'b1;
          txd_q       <= 1'b1;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_pin_master.sv
// Randomised scoreboard bench for uart_pin_master: a line decoder checks every
// transmitted byte, a response monitor checks every rsp_valid against a queue.
`timescale 1ns/1ps
module tb_uart_pin_master;

  localparam int CLK_HZ  = 1000;
  localparam int BAUD    = 250;
  localparam int TIMEOUT = 200;
  localparam int BD      = CLK_HZ / BAUD;

  logic       sys_clk = 1'b0;
  logic       sys_rst;
  logic       req_valid;
  logic       req_ready;
  logic       req_wr;
  logic [2:0] req_idx;
  logic [7:0] req_data;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_err;
  logic       busy;
  logic       uart_txd;
  logic       uart_rxd;

  uart_pin_master #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .TIMEOUT_CYC(TIMEOUT)) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_wr   (req_wr),
    .req_idx  (req_idx),
    .req_data (req_data),
    .rsp_valid(rsp_valid),
    .rsp_data (rsp_data),
    .rsp_err  (rsp_err),
    .busy     (busy),
    .uart_txd (uart_txd),
    .uart_rxd (uart_rxd)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  typedef struct { int data; int err; int lo; int hi; } rsp_t;
  typedef struct { int b; int start; } tx_t;
  rsp_t rsp_q[$];
  tx_t  tx_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
    n_cmp++;
    if (act < lo || act > hi) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d..%0d", nm, act, lo, hi);
    end
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge sys_clk);
  endtask

  // Response monitor
  rsp_t mon_e;
  always @(negedge sys_clk) begin
    if (!sys_rst && rsp_valid) begin
      $display("rsp cycle %0d data=%02h err=%0b", cyc, rsp_data, rsp_err);
      if (rsp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_rsp: got data=%02h err=%0b at cycle %0d, required no response",
                 rsp_data, rsp_err, cyc);
      end else begin
        mon_e = rsp_q.pop_front();
        chk("rsp_data", int'(rsp_data), mon_e.data);
        chk("rsp_err", int'(rsp_err), mon_e.err);
        chk_rng("rsp_cycle", cyc, mon_e.lo, mon_e.hi);
        chk("busy_vs_ready", int'(busy), int'(!req_ready));
      end
    end
  end

  // Line decoder for uart_txd: 10 bits of BD cycles each
  initial begin : tx_mon
    logic [10*BD-1:0] smp;
    logic [7:0]       bv;
    int               s;
    int               bad_w;
    bit               ab;
    tx_t              te;
    forever begin
      @(negedge sys_clk);
      if (!sys_rst && uart_txd === 1'b0) begin
        s      = cyc;
        smp    = '0;
        ab     = 1'b0;
        for (int i = 1; i < 10 * BD; i++) begin
          @(negedge sys_clk);
          if (sys_rst) begin
            ab = 1'b1;
            break;
          end
          smp[i] = uart_txd;
        end
        if (!ab) begin
          bad_w = 0;
          for (int k = 0; k < 10; k++)
            for (int j = 1; j < BD; j++)
              if (smp[BD*k+j] !== smp[BD*k]) bad_w++;
          for (int k = 0; k < 8; k++) bv[k] = smp[BD*(k+1)];
          $display("tx byte %02h start cycle %0d", bv, s);
          if (tx_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_tx: got byte %02h at cycle %0d, required none", bv, s);
          end else begin
            te = tx_q.pop_front();
            chk("tx_byte", int'(bv), te.b);
            chk("tx_start_cycle", s, te.start);
          end
          chk("tx_bit_width", bad_w, 0);
          chk("tx_stop_bit", int'(smp[9*BD]), 1);
        end
      end
    end
  end

  // Issues one request; E is the accepting edge. A held-valid request is
  // taken after a cycle with req_ready high or after the completion cycle.
  task automatic do_req(input bit wr, input logic [2:0] idx, input logic [7:0] d,
                        input bit hold, output int e);
    int guard;
    logic [7:0] cmd;
    @(negedge sys_clk);
    req_valid = 1'b1;
    req_wr    = wr;
    req_idx   = idx;
    req_data  = d;
    guard     = 0;
    while (!(req_ready || rsp_valid) && guard < 2000) begin
      @(negedge sys_clk);
      guard++;
    end
    if (guard >= 2000) chk("accept_timeout", 0, 1);
    e = cyc + 1;
    @(posedge sys_clk);
    cmd = {wr, 4'b0000, idx};
    tx_q.push_back('{b: int'(cmd), start: e + 1});
    if (wr) begin
      tx_q.push_back('{b: int'(d), start: e + 1 + 10 * BD});
      rsp_q.push_back('{data: 0, err: 0, lo: e + 1 + 20 * BD, hi: e + 1 + 20 * BD});
    end
    if (!hold) begin
      #1;
      req_valid = 1'b0;
    end
  endtask

  task automatic rx_send(input logic [7:0] b, input logic stop);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_rxd = fr[i];
      repeat (BD) @(negedge sys_clk);
    end
    uart_rxd = 1'b1;
  endtask

  // mode 0: good byte, 1: stop bit 0, 2: silent line
  task automatic do_read(input logic [2:0] idx, input int mode, input logic [7:0] b,
                         input int gap, input bit glitch, input bit junk);
    int e;
    int c;
    do_req(1'b0, idx, 8'h00, 1'b0, e);
    @(negedge sys_clk);
    if (junk) rx_send(8'hF0, 1'b1);
    wait_until(e + 1 + 10 * BD);
    if (mode == 2) begin
      rsp_q.push_back('{data: 0, err: 1, lo: e + 10 * BD + TIMEOUT, hi: e + 2 + 10 * BD + TIMEOUT});
      wait_until(e + 20 + 10 * BD + TIMEOUT);
    end else begin
      repeat (gap) @(negedge sys_clk);
      if (glitch) begin
        uart_rxd = 1'b0;
        @(negedge sys_clk);
        uart_rxd = 1'b1;
        repeat (20) @(negedge sys_clk);
      end
      c = cyc;
      // stop-bit middle plus synchroniser latency bounds the completion cycle
      rsp_q.push_back('{data: int'(b), err: (mode == 1) ? 1 : 0, lo: c + 9 * BD + 2, hi: c + 10 * BD + 4});
      rx_send(b, (mode == 1) ? 1'b0 : 1'b1);
      repeat (BD + 4) @(negedge sys_clk);
    end
  endtask

  initial begin : watchdog
    #600_000;
    $display("FAIL watchdog: simulation did not finish, required completion within 60000 cycles");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int e;
    int e1;
    int e2;
    int cnt_rsp;
    int cnt_low;
    sys_rst   = 1'b1;
    req_valid = 1'b0;
    req_wr    = 1'b0;
    req_idx   = '0;
    req_data  = '0;
    uart_rxd  = 1'b1;
    repeat (3) @(negedge sys_clk);
    chk("reset_txd", int'(uart_txd), 1);
    chk("reset_req_ready", int'(req_ready), 1);
    chk("reset_busy", int'(busy), 0);
    chk("reset_rsp_valid", int'(rsp_valid), 0);
    chk("reset_rsp_data", int'(rsp_data), 0);
    chk("reset_rsp_err", int'(rsp_err), 0);
    sys_rst = 1'b0;
    repeat (3) @(negedge sys_clk);

    // Write idx 5 / 0xA5 with junk request inputs wiggled while busy
    do_req(1'b1, 3'd5, 8'hA5, 1'b0, e);
    repeat (3) @(negedge sys_clk);
    chk("busy_during_tx", int'(busy), 1);
    for (int i = 0; i < 50; i++) begin
      req_valid = 1'b1;
      req_wr    = 1'($urandom_range(0, 1));
      req_idx   = 3'($urandom_range(0, 7));
      req_data  = 8'($urandom_range(0, 255));
      @(negedge sys_clk);
    end
    req_valid = 1'b0;
    wait_until(e + 3 + 20 * BD);

    do_read(3'd2, 0, 8'h3C, 30, 1'b0, 1'b0);
    do_read(3'd6, 2, 8'h00, 0, 1'b0, 1'b0);
    do_read(3'd1, 1, 8'h55, 12, 1'b0, 1'b0);
    do_read(3'd4, 0, 8'h81, 10, 1'b1, 1'b0);
    do_read(3'd7, 0, 8'hC3, 20, 1'b0, 1'b1);

    // Back-to-back writes with req_valid held
    do_req(1'b1, 3'd3, 8'h5A, 1'b1, e1);
    do_req(1'b1, 3'd6, 8'hC7, 1'b0, e2);
    chk("b2b_accept_edge", e2, e1 + 2 + 20 * BD);
    wait_until(e2 + 3 + 20 * BD);

    // Reset in the middle of the payload byte
    do_req(1'b1, 3'd0, 8'h0F, 1'b0, e);
    wait_until(e + 15 * BD);
    #2;
    sys_rst = 1'b1;
    #1;
    chk("midreset_txd", int'(uart_txd), 1);
    chk("midreset_req_ready", int'(req_ready), 1);
    chk("midreset_rsp_valid", int'(rsp_valid), 0);
    rsp_q.delete();
    tx_q.delete();
    repeat (2) @(negedge sys_clk);
    sys_rst = 1'b0;
    cnt_rsp = 0;
    cnt_low = 0;
    for (int i = 0; i < 30 * BD; i++) begin
      @(negedge sys_clk);
      if (rsp_valid) cnt_rsp++;
      if (!uart_txd) cnt_low++;
    end
    chk("no_rsp_after_reset", cnt_rsp, 0);
    chk("txd_idle_after_reset", cnt_low, 0);
    chk("rsp_data_after_reset", int'(rsp_data), 0);

    // Randomised mix of writes and reads
    for (int n = 0; n < 14; n++) begin
      bit         wr;
      logic [2:0] idx;
      logic [7:0] d;
      int         mode;
      wr   = 1'($urandom_range(0, 1));
      idx  = 3'($urandom_range(0, 7));
      d    = 8'($urandom_range(0, 255));
      mode = $urandom_range(0, 5);
      if (wr) begin
        do_req(1'b1, idx, d, 1'b0, e);
        wait_until(e + 3 + 20 * BD);
      end else begin
        do_read(idx, (mode == 0) ? 2 : (mode == 1) ? 1 : 0, d,
                $urandom_range(3, 60), bit'($urandom_range(0, 1)), 1'b0);
      end
    end

    repeat (10) @(negedge sys_clk);
    chk("rsp_queue_drained", rsp_q.size(), 0);
    chk("tx_queue_drained", tx_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
